// File: rtl/bridge_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : bridge_seq_ctrl_if                                            |
// | Purpose   : Groups the request/configuration/status signals and the       |
// |             H-bridge driver signals of bridge_seq_ctrl.                   |
// | Modports  : master - the sequencer (reads cfg/start, drives br_* and      |
// |                      status).                                             |
// |             slave  - the surrounding control logic / bridge model.        |
// | Signals   : start, cfg_half[HW], cfg_burst[BW], cfg_gap[GW], cfg_rep[NW], |
// |             br_load, br_halfdata[HW], br_reset, busy, done, rep_cnt[NW]   |
// |             abort, aborted (only when SEQ_ABORT_EN is defined)            |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bridge_seq_ctrl_if #(
   parameter int HW = 6,
   parameter int BW = 16,
   parameter int GW = 16,
   parameter int NW = 8
);
   logic          start;
   logic [HW-1:0] cfg_half;
   logic [BW-1:0] cfg_burst;
   logic [GW-1:0] cfg_gap;
   logic [NW-1:0] cfg_rep;
   logic          br_load;
   logic [HW-1:0] br_halfdata;
   logic          br_reset;
   logic          busy;
   logic          done;
   logic [NW-1:0] rep_cnt;
`ifdef SEQ_ABORT_EN
   logic          abort;
   logic          aborted;
`endif

   modport master (
`ifdef SEQ_ABORT_EN
      input  abort,
      output aborted,
`endif
      input  start, cfg_half, cfg_burst, cfg_gap, cfg_rep,
      output br_load, br_halfdata, br_reset, busy, done, rep_cnt
   );

   modport slave (
`ifdef SEQ_ABORT_EN
      output abort,
      input  aborted,
`endif
      output start, cfg_half, cfg_burst, cfg_gap, cfg_rep,
      input  br_load, br_halfdata, br_reset, busy, done, rep_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bridge_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : bridge_seq_ctrl                                               |
// | Purpose   : Sequencer for the H-bridge excitation driver. Programs the    |
// |             bridge half-period (br_halfdata/br_load), then gates the      |
// |             bridge through br_reset to produce cfg_rep bursts of          |
// |             cfg_burst cycles separated by cfg_gap idle cycles.            |
// | Ports     : clkin       in   sole clock, posedge                          |
// |             reset       in   asynchronous, active-low                     |
// |             bus         if   bridge_seq_ctrl_if.master                    |
// |               start/cfg_*    request and run configuration                |
// |               br_load        load strobe, rising edge captures data       |
// |               br_halfdata    half-period data to the bridge               |
// |               br_reset       active-high bridge hold (0 = running)        |
// |               busy/done      run status, one-cycle completion pulse       |
// |               rep_cnt        bursts completed in current/last run         |
// | Options   : SEQ_ABORT_EN - adds bus.abort / bus.aborted early termination |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bridge_seq_ctrl #(
   parameter int HW         = 6,
   parameter int BW         = 16,
   parameter int GW         = 16,
   parameter int NW         = 8,
   parameter int SETTLE_CYC = 4
) (
   input  wire logic            clkin,
   input  wire logic            reset,
   bridge_seq_ctrl_if.master    bus
);

   // One shared down-counter times SETTLE, BURST and GAP.
   localparam int              c_CW     = (BW > GW) ? BW : GW;
   localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);
   localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE_CYC);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_SETTLE = 3'd3,
      S_BURST  = 3'd4,
      S_GAP    = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t          r_state,       w_state_nxt;
   logic [c_CW-1:0] r_cnt,         w_cnt_nxt;
   logic [BW-1:0]   r_sh_burst,    w_sh_burst_nxt;
   logic [GW-1:0]   r_sh_gap,      w_sh_gap_nxt;
   logic [NW-1:0]   r_sh_rep,      w_sh_rep_nxt;
   logic [NW-1:0]   r_rep_cnt,     w_rep_cnt_nxt;
   logic [HW-1:0]   r_br_halfdata, w_br_halfdata_nxt;
   logic            r_br_load,     w_br_load_nxt;
   logic            r_br_reset,    w_br_reset_nxt;
   logic            r_busy,        w_busy_nxt;
   logic            r_done,        w_done_nxt;
   logic            w_abort;
   logic            w_abort_hit;
   logic            w_start_acc;

`ifdef SEQ_ABORT_EN
   logic            r_aborted;
   assign w_abort     = bus.abort;
   assign bus.aborted = r_aborted;
`else
   assign w_abort     = 1'b0;
`endif

   // Abort is only meaningful while a run is in flight.
   assign w_abort_hit = w_abort && (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_start_acc = (r_state == S_IDLE) && bus.start;

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_sh_burst_nxt    = r_sh_burst;
      w_sh_gap_nxt      = r_sh_gap;
      w_sh_rep_nxt      = r_sh_rep;
      w_rep_cnt_nxt     = r_rep_cnt;
      w_br_halfdata_nxt = r_br_halfdata;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_sh_burst_nxt = bus.cfg_burst;
               w_sh_gap_nxt   = bus.cfg_gap;
               w_sh_rep_nxt   = bus.cfg_rep;
               w_rep_cnt_nxt  = '0;
               if ((bus.cfg_rep == '0) || (bus.cfg_burst == '0)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  // Data goes out on entry to SETUP so it is stable for a
                  // full cycle before the strobe rises.
                  w_br_halfdata_nxt = bus.cfg_half;
                  w_state_nxt       = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            w_state_nxt = S_STROBE;
         end
         S_STROBE: begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = c_SETTLE;
         end
         S_SETTLE: begin
            if (r_cnt <= c_ONE) begin
               w_state_nxt = S_BURST;
               w_cnt_nxt   = c_CW'(r_sh_burst);
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
         S_BURST: begin
            if (r_cnt <= c_ONE) begin
               w_rep_cnt_nxt = r_rep_cnt + NW'(1);
               if ((r_rep_cnt + NW'(1)) == r_sh_rep) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_GAP;
                  // A zero gap still needs one high cycle to restart the bridge.
                  w_cnt_nxt   = (r_sh_gap == '0) ? c_ONE : c_CW'(r_sh_gap);
               end
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
         S_GAP: begin
            if (r_cnt <= c_ONE) begin
               w_state_nxt = S_BURST;
               w_cnt_nxt   = c_CW'(r_sh_burst);
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // An abort cancels whatever the state decode chose, including a burst
      // completion on the same edge: only fully completed bursts count.
      if (w_abort_hit) begin
         w_state_nxt   = S_DONE;
         w_rep_cnt_nxt = r_rep_cnt;
      end

      // Outputs are registered from the next state so they change only on
      // the clock edge and line up exactly with the state they describe.
      w_br_load_nxt  = (w_state_nxt == S_STROBE);
      w_br_reset_nxt = (w_state_nxt != S_BURST);
      w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      w_done_nxt     = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_sh_burst    <= '0;
         r_sh_gap      <= '0;
         r_sh_rep      <= '0;
         r_rep_cnt     <= '0;
         r_br_halfdata <= '0;
         r_br_load     <= 1'b0;
         r_br_reset    <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_sh_burst    <= w_sh_burst_nxt;
         r_sh_gap      <= w_sh_gap_nxt;
         r_sh_rep      <= w_sh_rep_nxt;
         r_rep_cnt     <= w_rep_cnt_nxt;
         r_br_halfdata <= w_br_halfdata_nxt;
         r_br_load     <= w_br_load_nxt;
         r_br_reset    <= w_br_reset_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
      end
   end

`ifdef SEQ_ABORT_EN
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         r_aborted <= 1'b0;
      end else if (w_start_acc) begin
         r_aborted <= 1'b0;
      end else if (w_abort_hit) begin
         r_aborted <= 1'b1;
      end
   end
`endif

   assign bus.br_load     = r_br_load;
   assign bus.br_halfdata = r_br_halfdata;
   assign bus.br_reset    = r_br_reset;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.rep_cnt     = r_rep_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bridge_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_bridge_seq_ctrl                                            |
// | Purpose   : Self-checking bench for bridge_seq_ctrl. A table of run       |
// |             configurations with expected latency/results drives the DUT; |
// |             a cycle monitor compares burst/gap lengths, load events and   |
// |             done results against expectations queued at stimulus time.    |
// | Options   : SEQ_ABORT_EN - also exercises the abort sequence             |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bridge_seq_ctrl;

   localparam int HW = 6;
   localparam int BW = 16;
   localparam int GW = 16;
   localparam int NW = 8;
   localparam int SETTLE_CYC = 4;

   logic clkin = 1'b0;
   logic reset = 1'b0;
   always #5 clkin = ~clkin;

   bridge_seq_ctrl_if #(.HW(HW), .BW(BW), .GW(GW), .NW(NW)) bus ();

   bridge_seq_ctrl #(
      .HW(HW), .BW(BW), .GW(GW), .NW(NW), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard queues and monitor ----------------
   int bq[$];   // expected burst (br_reset low) lengths
   int gq[$];   // expected gap (br_reset high between bursts) lengths
   int dq[$];   // expected rep_cnt at each done pulse
   int lq[$];   // expected br_halfdata at each br_load rise

   int          low_len  = 0;
   int          high_len = 0;
   int          n_loads  = 0;
   bit          after_burst = 1'b0;
   logic        prev_brr  = 1'b1;
   logic        prev_load = 1'b0;
   logic [HW-1:0] prev_half = '0;

   always @(negedge clkin) begin
      if (!reset) begin
         low_len     = 0;
         after_burst = 1'b0;
      end else begin
         if (bus.br_load && !prev_load) begin
            n_loads++;
            if (lq.size() == 0) chk("load_unexpected", 1, 0);
            else                chk("load_half", bus.br_halfdata, lq.pop_front());
            chk("half_setup", prev_half, bus.br_halfdata);
         end
         if (!bus.br_load && prev_load)
            chk("half_hold", bus.br_halfdata, prev_half);
         if (!bus.br_reset) begin
            if (prev_brr && after_burst) begin
               if (gq.size() == 0) chk("gap_unexpected", 1, 0);
               else                chk("gap_len", high_len, gq.pop_front());
            end
            after_burst = 1'b0;
            low_len++;
         end else begin
            if (!prev_brr) begin
               if (bq.size() == 0) chk("burst_unexpected", 1, 0);
               else                chk("burst_len", low_len, bq.pop_front());
               low_len     = 0;
               after_burst = 1'b1;
               high_len    = 1;
            end else if (after_burst) begin
               high_len++;
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else                chk("done_rep_cnt", bus.rep_cnt, dq.pop_front());
            after_burst = 1'b0;
         end
      end
      prev_brr  = bus.br_reset;
      prev_load = bus.br_load;
      prev_half = bus.br_halfdata;
   end

   // ---------------- vector table ----------------
   typedef struct {
      int half;
      int burst;
      int gap;
      int rep;
      int exp_lat;     // edges from the accepting edge until done is seen
      int exp_rep;
      int exp_half;
      int exp_loads;
      bit disturb;     // pulse start with new cfg in the middle of the run
      bit start_done;  // hold start during the DONE cycle
   } vec_t;

   vec_t tbl[7];

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      int loads0;
      loads0 = n_loads;
      if (v.rep != 0 && v.burst != 0) begin
         for (int i = 0; i < v.rep; i++)     bq.push_back(v.burst);
         for (int i = 0; i < v.rep - 1; i++) gq.push_back((v.gap == 0) ? 1 : v.gap);
         lq.push_back(v.half);
      end
      dq.push_back(v.exp_rep);

      @(negedge clkin);
      bus.cfg_half  = HW'(v.half);
      bus.cfg_burst = BW'(v.burst);
      bus.cfg_gap   = GW'(v.gap);
      bus.cfg_rep   = NW'(v.rep);
      bus.start     = 1'b1;
      @(posedge clkin); #1;
      bus.start = 1'b0;
      lat = 0;
      chk({tag, "_busy_acc"}, bus.busy, (v.exp_lat != 0));
      while (!bus.done && lat < 3000) begin
         if (v.disturb && lat == 60) begin
            bus.start     = 1'b1;
            bus.cfg_half  = HW'(20);
            bus.cfg_burst = BW'(5);
            bus.cfg_gap   = GW'(0);
            bus.cfg_rep   = NW'(1);
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clkin); #1;
         lat++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_rep_cnt"}, bus.rep_cnt, v.exp_rep);
      chk({tag, "_halfdata"}, bus.br_halfdata, v.exp_half);
      chk({tag, "_busy_done"}, bus.busy, 0);
      chk({tag, "_br_reset_done"}, bus.br_reset, 1);
      if (v.start_done) begin
         bus.start = 1'b1;
         @(posedge clkin); #1;
         bus.start = 1'b0;
         chk({tag, "_sd_busy"}, bus.busy, 0);
         chk({tag, "_sd_done"}, bus.done, 0);
         @(posedge clkin); #1;
         chk({tag, "_sd_busy2"}, bus.busy, 0);
      end
      repeat (2) @(negedge clkin);
      chk({tag, "_loads"}, n_loads - loads0, v.exp_loads);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: still running at t=%0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bad;
      //              half burst gap rep lat rep half loads dist sd
      tbl[0] = '{12, 40, 10, 3, 146, 3, 12, 1, 1'b0, 1'b0};
      tbl[1] = '{12, 40, 10, 3, 146, 3, 12, 1, 1'b1, 1'b1};
      tbl[2] = '{ 5,  1,  0, 2,   9, 2,  5, 1, 1'b0, 1'b0};
      tbl[3] = '{33,  7,  3, 0,   0, 0,  5, 0, 1'b0, 1'b0};
      tbl[4] = '{44,  0,  2, 4,   0, 0,  5, 0, 1'b0, 1'b1};
      tbl[5] = '{63,  3,  2, 1,   9, 1, 63, 1, 1'b0, 1'b0};
      tbl[6] = '{ 1,  2,  1, 4,  17, 4,  1, 1, 1'b0, 1'b1};

      bus.start     = 1'b0;
      bus.cfg_half  = '0;
      bus.cfg_burst = '0;
      bus.cfg_gap   = '0;
      bus.cfg_rep   = '0;
`ifdef SEQ_ABORT_EN
      bus.abort     = 1'b0;
`endif

      // Reset state while held and after release.
      reset = 1'b0;
      repeat (3) @(negedge clkin);
      chk("rst_br_reset", bus.br_reset, 1);
      chk("rst_br_load", bus.br_load, 0);
      chk("rst_halfdata", bus.br_halfdata, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rep_cnt", bus.rep_cnt, 0);
      reset = 1'b1;
      repeat (2) begin @(posedge clkin); #1; end
      chk("rel_br_reset", bus.br_reset, 1);
      chk("rel_br_load", bus.br_load, 0);
      chk("rel_busy", bus.busy, 0);
      chk("rel_done", bus.done, 0);

      for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Asynchronous reset in the middle of the first burst.
      lq.push_back(9);
      @(negedge clkin);
      bus.cfg_half  = HW'(9);
      bus.cfg_burst = BW'(30);
      bus.cfg_gap   = GW'(5);
      bus.cfg_rep   = NW'(2);
      bus.start     = 1'b1;
      @(posedge clkin); #1;
      bus.start = 1'b0;
      repeat (16) begin @(posedge clkin); #1; end
      chk("ar_in_burst", bus.br_reset, 0);
      #3 reset = 1'b0;
      #1;
      chk("ar_br_reset", bus.br_reset, 1);
      chk("ar_busy", bus.busy, 0);
      chk("ar_br_load", bus.br_load, 0);
      chk("ar_halfdata", bus.br_halfdata, 0);
      chk("ar_rep_cnt", bus.rep_cnt, 0);
      repeat (3) @(negedge clkin);
      reset = 1'b1;
      bad = 0;
      repeat (6) begin
         @(posedge clkin); #1;
         if (bus.done || bus.busy) bad++;
      end
      chk("ar_no_done", bad, 0);

`ifdef SEQ_ABORT_EN
      // Abort during the second burst of a 3 x 10 run with 4-cycle gaps.
      lq.push_back(7);
      bq.push_back(10);
      bq.push_back(5);
      gq.push_back(4);
      dq.push_back(1);
      @(negedge clkin);
      bus.cfg_half  = HW'(7);
      bus.cfg_burst = BW'(10);
      bus.cfg_gap   = GW'(4);
      bus.cfg_rep   = NW'(3);
      bus.start     = 1'b1;
      @(posedge clkin); #1;
      bus.start = 1'b0;
      repeat (24) begin @(posedge clkin); #1; end
      chk("ab_in_burst2", bus.br_reset, 0);
      bus.abort = 1'b1;
      @(posedge clkin); #1;
      bus.abort = 1'b0;
      chk("ab_br_reset", bus.br_reset, 1);
      chk("ab_done", bus.done, 1);
      chk("ab_aborted", bus.aborted, 1);
      chk("ab_rep_cnt", bus.rep_cnt, 1);
      chk("ab_busy", bus.busy, 0);
      repeat (2) @(negedge clkin);
      run_vec(tbl[5], "ab_rerun");
      chk("ab_aborted_clr", bus.aborted, 0);
`endif

      repeat (3) @(negedge clkin);
      chk("sb_empty", bq.size() + gq.size() + dq.size() + lq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
